rotation_matrix_sequencer: RTL

//  Sequences the matrix_product rotation datapath for one image-rotation request.
//  On a start pulse it latches the angle code, drives it onto mp_aci and waits for the

---
 rtl/rot_seq_pkg.sv | 23 ++
 rtl/rot_seq_timer.sv | 34 +++
 rtl/rotation_matrix_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rot_seq_pkg.sv
// Shared types and constants for the rotation matrix sequencer: state encoding,
// element/selection widths and the Q13.20 unity constant.
package rot_seq_pkg;

  localparam int SEL_W      = 3;
  localparam int DATA_W     = 33;
  localparam int N_ELEM     = 8;
  localparam int ANGLE_MAX  = 6;
  localparam int SETTLE_CYC = 2;
  localparam int SAMPLE_LAT = 1;
  localparam int TMR_W      = 4;

  localparam logic [DATA_W-1:0] ONE = 33'h0_0010_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/rot_seq_timer.sv
// Loadable down-counter shared by the settle and sample phases; expired is high
// in the last counted cycle so a load of N gives an N-cycle phase.
module rot_seq_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q <= CNT_W'(1));

endmodule

// File: rtl/rotation_matrix_sequencer.sv
// Sequences matrix_product for one rotation request and streams the captured
// Q13.20 elements downstream. Optional replay cache: ROT_SEQ_CACHE_EN.
module rotation_matrix_sequencer
  import rot_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        aci,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        mp_aci,
  output logic [SEL_W-1:0]  mp_selection,
  input  logic [DATA_W-1:0] mp_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data
);

  state_e state_q, state_d;

  logic [2:0]        mp_aci_q, mp_aci_d;
  logic [SEL_W-1:0]  mp_sel_q, mp_sel_d;
  logic [SEL_W-1:0]  out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;

  logic              accept, reject, hs, last, hit, replay;
  logic [DATA_W-1:0] cache_rd;

  assign accept = (state_q == ST_IDLE) && start && (aci <= 3'(ANGLE_MAX));
  assign reject = (state_q == ST_IDLE) && start && (aci > 3'(ANGLE_MAX));
  assign hs     = (state_q == ST_HOLD) && out_valid_q && out_ready;
  assign last   = (out_index_q == SEL_W'(N_ELEM - 1));

  rot_seq_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

`ifdef ROT_SEQ_CACHE_EN
  logic [DATA_W-1:0] cache_q [N_ELEM];
  logic [2:0]        cache_ang_q, cache_ang_d;
  logic              cache_vld_q, cache_vld_d;
  logic              replay_q, replay_d;
  logic [SEL_W-1:0]  rd_idx;

  assign hit      = cache_vld_q && (aci == cache_ang_q);
  assign replay   = replay_q;
  assign rd_idx   = (state_q == ST_IDLE) ? '0 : out_index_q + 1'b1;
  assign cache_rd = cache_q[rd_idx];

  // Cache contents are only trusted once a full sweep has completed.
  always_comb begin
    cache_ang_d = cache_ang_q;
    cache_vld_d = cache_vld_q;
    replay_d    = replay_q;
    if (reject || (accept && !hit)) begin
      cache_vld_d = 1'b0;
    end
    if (accept) begin
      replay_d = hit;
    end
    if ((state_q == ST_FINISH) && !replay_q) begin
      cache_vld_d = 1'b1;
      cache_ang_d = mp_aci_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_ang_q <= '0;
      cache_vld_q <= 1'b0;
      replay_q    <= 1'b0;
    end else begin
      cache_ang_q <= cache_ang_d;
      cache_vld_q <= cache_vld_d;
      replay_q    <= replay_d;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == ST_SAMPLE) && tmr_exp) begin
      cache_q[mp_sel_q] <= mp_value;
    end
  end
`else
  assign hit      = 1'b0;
  assign replay   = 1'b0;
  assign cache_rd = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mp_aci_q    <= '0;
      mp_sel_q    <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mp_aci_q    <= mp_aci_d;
      mp_sel_q    <= mp_sel_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = hit ? ST_HOLD : ST_SETTLE;
      ST_SETTLE: if (tmr_exp) state_d = ST_SAMPLE;
      ST_SAMPLE: if (tmr_exp) state_d = ST_HOLD;
      ST_HOLD:   if (hs) state_d = last ? ST_FINISH : (replay ? ST_HOLD : ST_SAMPLE);
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load    = 1'b0;
    tmr_val     = TMR_W'(SAMPLE_LAT);
    mp_aci_d    = mp_aci_q;
    mp_sel_d    = mp_sel_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = reject;
    case (state_q)
      ST_IDLE: begin
        if (accept && hit) begin
          out_valid_d = 1'b1;
          out_index_d = '0;
          out_data_d  = cache_rd;
        end else if (accept) begin
          mp_aci_d = aci;
          mp_sel_d = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SETTLE_CYC);
        end
      end
      ST_SETTLE: begin
        tmr_load = tmr_exp;
      end
      ST_SAMPLE: begin
        if (tmr_exp) begin
          out_data_d  = mp_value;
          out_index_d = mp_sel_q;
          out_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hs) begin
          out_valid_d = 1'b0;
          if (!last && replay) begin
            out_valid_d = 1'b1;
            out_index_d = out_index_q + 1'b1;
            out_data_d  = cache_rd;
          end else if (!last) begin
            mp_sel_d = mp_sel_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_HOLD);
    done         = (state_q == ST_FINISH);
    err          = err_q;
    mp_aci       = mp_aci_q;
    mp_selection = mp_sel_q;
    out_valid    = out_valid_q;
    out_index    = out_index_q;
    out_data     = out_data_q;
  end

endmodule
